mips_multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the MIPS core. It replaces single-cycle combinational decode with an FSM of FETCH/DECODE/EXEC/MEM/WB states and a variable-latency memory handshake. A configurable multi-cycle stall covers mult/div, and a sticky halt/fault path is included. It drives the datapath's select and enable lines and the ALU control code, and it keeps retired-instruction and cycle counters.

---
 rtl/mips_multicycle_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS core.
// Walks FETCH/DECODE/EXEC/MEM/WB, handles a variable-latency memory handshake
// with a bus-timeout fault, stalls EXEC for mult/div, and keeps retire/cycle
// counters. HALT is sticky until reset; outputs are forced idle during reset.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT   = 16,
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32,
  parameter int ALU_CTL_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 alu_zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  output logic [1:0]           alu_src_b,
  output logic                 rf_we,
  output logic                 rf_waddr_sel,
  output logic [1:0]           rf_wdata_sel,
  output logic                 halted,
  output logic [1:0]           fault,
  output logic [CNT_W-1:0]     retire_cnt,
  output logic [CNT_W-1:0]     cycle_cnt
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int STALL_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(MULDIV_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Instruction classes that steer the sequencing after DECODE.
  typedef enum logic [3:0] {
    CL_ALU     = 4'd0,
    CL_MULDIV  = 4'd1,
    CL_BEQ     = 4'd2,
    CL_BNE     = 4'd3,
    CL_LW      = 4'd4,
    CL_SW      = 4'd5,
    CL_LUI     = 4'd6,
    CL_JUMP    = 4'd7,
    CL_SYSCALL = 4'd8
  } cls_t;

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [STALL_W-1:0]   stall_cnt;

  logic                 dec_legal;
  logic                 dec_rtype;
  cls_t                 dec_cls;
  logic [ALU_CTL_W-1:0] dec_alu;
  logic [1:0]           dec_src_b;
  logic                 mem_timeout;

  // Instruction decode: class, ALU code and operand-B select from opcode/func.
  always_comb begin
    dec_legal = 1'b1;
    dec_rtype = (opcode == 6'b000000);
    dec_cls   = CL_ALU;
    dec_alu   = ALU_CTL_W'(0);
    dec_src_b = 2'd0;
    case (opcode)
      6'b000000: begin
        case (func)
          6'b000000: begin dec_alu = ALU_CTL_W'(9);  dec_src_b = 2'd3; end // sll
          6'b000010: begin dec_alu = ALU_CTL_W'(8);  dec_src_b = 2'd3; end // srl
          6'b000011: begin dec_alu = ALU_CTL_W'(10); dec_src_b = 2'd3; end // sra
          6'b000100: dec_alu = ALU_CTL_W'(9);                              // sllv
          6'b000110: dec_alu = ALU_CTL_W'(8);                              // srlv
          6'b001100: dec_cls = CL_SYSCALL;                                 // syscall
          6'b011000: begin dec_alu = ALU_CTL_W'(2); dec_cls = CL_MULDIV; end // mult
          6'b011010: begin dec_alu = ALU_CTL_W'(3); dec_cls = CL_MULDIV; end // div
          6'b100000: dec_alu = ALU_CTL_W'(0);                              // add
          6'b100001: dec_alu = ALU_CTL_W'(0);                              // addu
          6'b100010: dec_alu = ALU_CTL_W'(1);                              // sub
          6'b100011: dec_alu = ALU_CTL_W'(1);                              // subu
          6'b100100: dec_alu = ALU_CTL_W'(5);                              // and
          6'b100101: dec_alu = ALU_CTL_W'(6);                              // or
          6'b100110: dec_alu = ALU_CTL_W'(4);                              // xor
          6'b100111: dec_alu = ALU_CTL_W'(7);                              // nor
          6'b101010: dec_alu = ALU_CTL_W'(11);                             // slt
          default:   dec_legal = 1'b0;
        endcase
      end
      6'b000010: dec_cls = CL_JUMP;                                                  // j
      6'b000100: begin dec_cls = CL_BEQ; dec_alu = ALU_CTL_W'(12); end               // beq
      6'b000101: begin dec_cls = CL_BNE; dec_alu = ALU_CTL_W'(12); end               // bne
      6'b001000: begin dec_alu = ALU_CTL_W'(0); dec_src_b = 2'd1; end                // addi
      6'b001001: begin dec_alu = ALU_CTL_W'(0); dec_src_b = 2'd2; end                // addiu
      6'b001100: begin dec_alu = ALU_CTL_W'(5); dec_src_b = 2'd2; end                // andi
      6'b001101: begin dec_alu = ALU_CTL_W'(6); dec_src_b = 2'd2; end                // ori
      6'b001110: begin dec_alu = ALU_CTL_W'(4); dec_src_b = 2'd2; end                // xori
      6'b001111: dec_cls = CL_LUI;                                                   // lui
      6'b100011: begin dec_cls = CL_LW; dec_alu = ALU_CTL_W'(0); dec_src_b = 2'd1; end // lw
      6'b101011: begin dec_cls = CL_SW; dec_alu = ALU_CTL_W'(0); dec_src_b = 2'd1; end // sw
      default:   dec_legal = 1'b0;
    endcase
  end

  // Datapath control decode from state; everything idles while reset is held.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_ctl      = ALU_CTL_W'(0);
    alu_src_b    = 2'd0;
    rf_we        = 1'b0;
    rf_waddr_sel = 1'b0;
    rf_wdata_sel = 2'd0;
    if (!rst_b) begin
      mem_req = 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end else begin
            ir_we = 1'b0;
          end
        end
        ST_DECODE: begin
          if (dec_legal && dec_cls == CL_JUMP) begin
            pc_we  = 1'b1;
            pc_src = 2'd2;
          end else begin
            pc_we  = 1'b0;
          end
        end
        ST_EXEC: begin
          alu_ctl   = dec_alu;
          alu_src_b = dec_src_b;
          if ((dec_cls == CL_BEQ && alu_zero) || (dec_cls == CL_BNE && !alu_zero)) begin
            pc_we  = 1'b1;
            pc_src = 2'd1;
          end else begin
            pc_we  = 1'b0;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (dec_cls == CL_SW);
        end
        ST_WB: begin
          rf_we        = 1'b1;
          rf_waddr_sel = dec_rtype;
          if (dec_cls == CL_LW) begin
            rf_wdata_sel = 2'd1;
          end else if (dec_cls == CL_LUI) begin
            rf_wdata_sel = 2'd2;
          end else begin
            rf_wdata_sel = 2'd0;
          end
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

  // A request still waiting on its last permitted cycle becomes a bus fault.
  assign mem_timeout = mem_req && !mem_ready && (wait_cnt == WAIT_LAST);

  // Sequencer state, wait/stall counters, sticky halt/fault and statistics.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= ST_FETCH;
      wait_cnt   <= WAIT_W'(0);
      stall_cnt  <= STALL_W'(0);
      halted     <= 1'b0;
      fault      <= 2'd0;
      retire_cnt <= CNT_W'(0);
      cycle_cnt  <= CNT_W'(0);
    end else begin
      if (state != ST_HALT) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (mem_req && !mem_ready && !mem_timeout) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end else begin
        wait_cnt <= WAIT_W'(0);
      end
      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            state <= ST_DECODE;
          end else if (mem_timeout) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            fault  <= 2'd2;
          end
        end
        ST_DECODE: begin
          stall_cnt <= STALL_W'(0);
          if (!dec_legal) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            fault  <= 2'd1;
          end else if (dec_cls == CL_SYSCALL) begin
            state      <= ST_HALT;
            halted     <= 1'b1;
            retire_cnt <= retire_cnt + CNT_W'(1);
          end else if (dec_cls == CL_JUMP) begin
            state      <= ST_FETCH;
            retire_cnt <= retire_cnt + CNT_W'(1);
          end else begin
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (dec_cls)
            CL_BEQ, CL_BNE: begin
              state      <= ST_FETCH;
              retire_cnt <= retire_cnt + CNT_W'(1);
            end
            CL_LW, CL_SW: state <= ST_MEM;
            CL_MULDIV: begin
              if (stall_cnt == STALL_LAST) begin
                stall_cnt <= STALL_W'(0);
                state     <= ST_WB;
              end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
              end
            end
            default: state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (dec_cls == CL_SW) begin
              state      <= ST_FETCH;
              retire_cnt <= retire_cnt + CNT_W'(1);
            end else begin
              state <= ST_WB;
            end
          end else if (mem_timeout) begin
            state  <= ST_HALT;
            halted <= 1'b1;
            fault  <= 2'd2;
          end
        end
        ST_WB: begin
          state      <= ST_FETCH;
          retire_cnt <= retire_cnt + CNT_W'(1);
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with hand-computed expectations.
module tb_mips_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        alu_zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [3:0]  alu_ctl;
  logic [1:0]  alu_src_b;
  logic        rf_we;
  logic        rf_waddr_sel;
  logic [1:0]  rf_wdata_sel;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retire_cnt;
  logic [31:0] cycle_cnt;

  int tests = 0;
  int fails = 0;

  mips_multicycle_ctrl #(
    .MEM_TIMEOUT(16), .MULDIV_CYCLES(4), .CNT_W(32), .ALU_CTL_W(4)
  ) dut (
    .clk(clk), .rst_b(rst_b), .opcode(opcode), .func(func),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_ctl(alu_ctl), .alu_src_b(alu_src_b),
    .rf_we(rf_we), .rf_waddr_sel(rf_waddr_sel), .rf_wdata_sel(rf_wdata_sel),
    .halted(halted), .fault(fault), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH with memory answering in the same cycle as the request.
  task automatic fetch_ok(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func = fn;
    mem_ready = 1'b1;
    #1;
    chk("fetch_req", mem_req, 1);
    chk("fetch_irwe", ir_we, 1);
    tick();
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_b = 1'b0; opcode = 6'd0; func = 6'd0; alu_zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_irwe", ir_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_cycle", cycle_cnt, 0);
    mem_ready = 1'b0;
    rst_b = 1'b1;
    #1;
    chk("post_rst_req", mem_req, 1);

    // addi: FETCH-DECODE-EXEC-WB
    opcode = 6'b001000; func = 6'd0; mem_ready = 1'b1;
    #1;
    chk("addi_f_req", mem_req, 1);
    chk("addi_f_asel", mem_addr_sel, 0);
    chk("addi_f_pcwe", pc_we, 1);
    chk("addi_f_pcsrc", pc_src, 0);
    tick();
    mem_ready = 1'b0;
    chk("addi_d_req", mem_req, 0);
    tick();
    chk("addi_e_alu", alu_ctl, 0);
    chk("addi_e_srcb", alu_src_b, 1);
    chk("addi_e_rfwe", rf_we, 0);
    tick();
    chk("addi_wb_rfwe", rf_we, 1);
    chk("addi_wb_waddr", rf_waddr_sel, 0);
    chk("addi_wb_wdata", rf_wdata_sel, 0);
    tick();
    chk("addi_retire", retire_cnt, 1);
    chk("addi_cycle", cycle_cnt, 4);
    chk("addi_rfwe_off", rf_we, 0);

    // lw with three wait cycles in FETCH and in MEM
    opcode = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      chk("lw_f_req", mem_req, 1);
      chk("lw_f_asel", mem_addr_sel, 0);
      chk("lw_f_irwe", ir_we, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_f_accept", ir_we, 1);
    tick();
    mem_ready = 1'b0;
    tick();
    chk("lw_e_alu", alu_ctl, 0);
    chk("lw_e_srcb", alu_src_b, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("lw_m_req", mem_req, 1);
      chk("lw_m_asel", mem_addr_sel, 1);
      chk("lw_m_we", mem_we, 0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("lw_m_req4", mem_req, 1);
    tick();
    mem_ready = 1'b0;
    chk("lw_wb_rfwe", rf_we, 1);
    chk("lw_wb_wdata", rf_wdata_sel, 1);
    chk("lw_wb_waddr", rf_waddr_sel, 0);
    tick();
    chk("lw_retire", retire_cnt, 2);
    chk("lw_cycle", cycle_cnt, 15);

    // beq taken, then bne not taken, both with alu_zero=1
    alu_zero = 1'b1;
    fetch_ok(6'b000100, 6'd0);
    tick();
    chk("beq_alu", alu_ctl, 12);
    chk("beq_pcwe", pc_we, 1);
    chk("beq_pcsrc", pc_src, 1);
    tick();
    chk("beq_retire", retire_cnt, 3);
    fetch_ok(6'b000101, 6'd0);
    tick();
    chk("bne_alu", alu_ctl, 12);
    chk("bne_pcwe", pc_we, 0);
    tick();
    chk("bne_retire", retire_cnt, 4);
    chk("bne_back_fetch", mem_req, 1);
    alu_zero = 1'b0;

    // mult: four EXEC cycles then a single write-back
    fetch_ok(6'b000000, 6'b011000);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mult_e_alu", alu_ctl, 2);
      chk("mult_e_rfwe", rf_we, 0);
      tick();
    end
    chk("mult_wb_rfwe", rf_we, 1);
    chk("mult_wb_waddr", rf_waddr_sel, 1);
    tick();
    chk("mult_rfwe_once", rf_we, 0);
    chk("mult_retire", retire_cnt, 5);

    // sw: retires from MEM
    fetch_ok(6'b101011, 6'd0);
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    chk("sw_m_we", mem_we, 1);
    chk("sw_m_asel", mem_addr_sel, 1);
    tick();
    mem_ready = 1'b0;
    chk("sw_retire", retire_cnt, 6);
    chk("sw_no_rfwe", rf_we, 0);

    // j: retires from DECODE
    fetch_ok(6'b000010, 6'd0);
    chk("j_pcwe", pc_we, 1);
    chk("j_pcsrc", pc_src, 2);
    tick();
    chk("j_retire", retire_cnt, 7);
    chk("j_cycle", cycle_cnt, 34);

    // FETCH timeout after 16 wait cycles
    for (int i = 0; i < 16; i++) begin
      chk("to_not_halted", halted, 0);
      tick();
    end
    chk("to_halted", halted, 1);
    chk("to_fault", fault, 2);
    chk("to_req", mem_req, 0);
    chk("to_cycle", cycle_cnt, 50);
    chk("to_retire", retire_cnt, 7);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("halt_cycle_frozen", cycle_cnt, 50);
    chk("halt_req", mem_req, 0);
    chk("halt_irwe", ir_we, 0);
    chk("halt_pcwe", pc_we, 0);
    chk("halt_still", halted, 1);
    mem_ready = 1'b0;

    // reset pulse mid-HALT
    rst_b = 1'b0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_fault", fault, 0);
    chk("rst2_retire", retire_cnt, 0);
    chk("rst2_cycle", cycle_cnt, 0);
    tick();
    rst_b = 1'b1;
    #1;
    chk("rst2_fetch", mem_req, 1);

    // illegal opcode
    fetch_ok(6'b111111, 6'd0);
    chk("ill_pcwe", pc_we, 0);
    tick();
    chk("ill_halted", halted, 1);
    chk("ill_fault", fault, 1);
    chk("ill_retire", retire_cnt, 0);
    rst_b = 1'b0;
    #1;
    tick();
    rst_b = 1'b1;
    #1;

    // syscall
    fetch_ok(6'b000000, 6'b001100);
    tick();
    chk("sys_halted", halted, 1);
    chk("sys_fault", fault, 0);
    chk("sys_retire", retire_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
